ahb_sram_slave: RTL and testbench

// AHB slave memory: downstream of the AHB interface/master driver; responds to transfers on the bus.

---
 rtl/ahb_sram_slave.sv | 136 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM target: word-wide byte-addressable memory with programmable wait states
// and the two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned WW    = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned CW    = 4;
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            pend, pend_d;
  logic [AW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic            wr_q;
  logic [31:0]     mem [WORDS];

  logic            accept_c;
  logic            bad_c;
  logic            done_c;
  logic [3:0]      be_c;
  logic [WW-1:0]   widx_c;
  logic            unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  // Bus-visible response is a pure decode of the registered state.
  assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
  assign HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'd1 : 2'd0;

  assign accept_c = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign bad_c    = ({1'b0, HADDR} < {1'b0, BASE_ADDR}) || ({1'b0, HADDR} >= LIMIT) ||
                    (HSIZE > 3'd2) || ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  // An OKAY data phase completes in IDLE with the pending flag set.
  assign done_c = (state == S_IDLE) && pend;
  assign widx_c = WW'(addr_q >> 2);
  assign HRDATA = (done_c && !wr_q) ? mem[widx_c] : 32'h0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pend  <= pend_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pend_d  = 1'b0;
    case (state)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept_c) begin
          if (bad_c) begin
            state_d = S_ERR1;
          end else if (WAIT_CYCLES == 0) begin
            pend_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_d = S_IDLE;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      size_q <= '0;
      wr_q   <= 1'b0;
    end else if (accept_c) begin
      addr_q <= HADDR[AW-1:0];
      size_q <= HSIZE[1:0];
      wr_q   <= HWRITE;
    end
  end

  // Little-endian lane enables for the completing write.
  always_comb begin
    be_c = 4'b1111;
    case (size_q)
      2'd0:    be_c = 4'b0001 << addr_q[1:0];
      2'd1:    be_c = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge HCLK) begin
    if (done_c && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[widx_c][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 wait state @0x0, zero wait @0x1000) driven by
// a blocking AHB master; a per-instance monitor scores every data phase against a byte model.
module tb_ahb_sram_slave;

  localparam int unsigned MEM = 1024;
  localparam logic [31:0] BASES [2] = '{32'h0, 32'h1000};
  localparam int          WAITS [2] = '{1, 0};

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        hsel   [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hburst [2];
  logic [2:0]  hsize  [2];
  logic        hwrite [2];
  logic [31:0] haddr  [2];
  logic [31:0] hwdata [2];
  logic        hrdy   [2];
  logic [1:0]  hresp  [2];
  logic [31:0] hrdata [2];

  exp_t        expq [2][$];
  logic [7:0]  ref_mem [2][MEM];
  logic [31:0] pend_wdata [2];
  int          n_pass;
  int          n_total;

  ahb_sram_slave #(.MEM_BYTES(MEM), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HREADY(hrdy[0]), .HTRANS(htrans[0]),
    .HBURST(hburst[0]), .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HADDR(haddr[0]),
    .HWDATA(hwdata[0]), .HREADYOUT(hrdy[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave #(.MEM_BYTES(MEM), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HREADY(hrdy[1]), .HTRANS(htrans[1]),
    .HBURST(hburst[1]), .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HADDR(haddr[1]),
    .HWDATA(hwdata[1]), .HREADYOUT(hrdy[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
  endtask

  function automatic bit is_err(int d, logic [31:0] a, logic [2:0] s);
    longint off = longint'(a) - longint'(BASES[d]);
    if (off < 0 || off >= longint'(MEM)) return 1'b1;
    if (s > 3'd2) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  task automatic wait_accept(int d);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hrdy[d]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL accept_timeout dut%0d: HREADYOUT stayed 0, expected 1 within 40 cycles", d);
    $fatal(1, "bus hung");
  endtask

  // Present one address phase, update the model, queue the expected response.
  task automatic issue(int d, bit sel, logic [1:0] trans, bit wr, logic [31:0] a,
                       logic [2:0] s, logic [31:0] wdata);
    exp_t e;
    int   off;
    hwdata[d] = pend_wdata[d];
    hsel[d]   = sel;
    htrans[d] = trans;
    hwrite[d] = wr;
    haddr[d]  = a;
    hsize[d]  = s;
    hburst[d] = 3'($urandom_range(0, 7));
    if (sel && trans[1]) begin
      e.err  = is_err(d, a, s);
      e.rd   = !wr;
      e.data = 32'h0;
      if (!e.err) begin
        off = int'(a - BASES[d]);
        if (wr) begin
          for (int i = 0; i < (1 << s); i++)
            ref_mem[d][off+i] = wdata[8*((off+i) % 4) +: 8];
        end else begin
          off = off - off % 4;
          e.data = {ref_mem[d][off+3], ref_mem[d][off+2], ref_mem[d][off+1], ref_mem[d][off]};
        end
      end
      expq[d].push_back(e);
    end
    pend_wdata[d] = wdata;
    wait_accept(d);
  endtask

  task automatic idle(int d);
    issue(d, 1'b1, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  // Monitor: one scoring event per completed data phase.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      bit         in_data;
      bit         ph_xfer;
      int         low;
      logic [1:0] first_resp;
      logic [1:0] resp_or;
      exp_t       e;
      in_data = 1'b0;
      ph_xfer = 1'b0;
      low = 0;
      first_resp = 2'd0;
      resp_or = 2'd0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          in_data = 1'b0;
          continue;
        end
        if (in_data) begin
          if (!hrdy[g]) begin
            low++;
            if (low == 1) first_resp = hresp[g];
            resp_or |= hresp[g];
          end else if (!ph_xfer) begin
            chk("idle_waits", g, low, 0);
            chk("idle_resp", g, hresp[g], 0);
            chk("idle_rdata", g, hrdata[g], 0);
          end else if (expq[g].size() == 0) begin
            n_total++;
            $display("FAIL unexpected_xfer dut%0d t=%0t: got a completed transfer, expected none queued", g, $time);
          end else begin
            e = expq[g].pop_front();
            if (e.err) begin
              chk("err_waits", g, low, 1);
              chk("err_first_resp", g, first_resp, 1);
              chk("err_resp", g, hresp[g], 1);
            end else begin
              chk("ok_waits", g, low, WAITS[g]);
              chk("ok_wait_resp", g, resp_or, 0);
              chk("ok_resp", g, hresp[g], 0);
              chk("rdata", g, hrdata[g], e.rd ? e.data : 32'h0);
            end
          end
        end
        if (hrdy[g]) begin
          in_data    = 1'b1;
          low        = 0;
          resp_or    = 2'd0;
          first_resp = 2'd0;
          ph_xfer    = hsel[g] && htrans[g][1];
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  s;
    int          k;
    logic [31:0] b;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = 2'b00; hburst[d] = 3'd0; hsize[d] = 3'd0;
      hwrite[d] = 1'b0; haddr[d] = 32'h0; hwdata[d] = 32'h0; pend_wdata[d] = 32'h0;
    end
    #2 rst_n = 1'b0;
    #20;
    for (int d = 0; d < 2; d++) begin
      chk("rst_hreadyout", d, hrdy[d], 1);
      chk("rst_hresp", d, hresp[d], 0);
      chk("rst_hrdata", d, hrdata[d], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero the whole array of both instances so every later read is defined.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < int'(MEM / 4); w++)
        issue(d, 1'b1, 2'b10, 1'b1, BASES[d] + 32'(w * 4), 3'd2, 32'h0);
      idle(d);
    end

    // Reset in the middle of a write wait state: the write must be dropped.
    hwdata[0] = pend_wdata[0];
    hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h20; hsize[0] = 3'd2;
    wait_accept(0);
    chk("wait_state", 0, hrdy[0], 0);
    hwdata[0] = 32'hCAFEF00D;
    htrans[0] = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("midwait_rst_hreadyout", 0, hrdy[0], 1);
    chk("midwait_rst_hresp", 0, hresp[0], 0);
    chk("midwait_rst_hrdata", 0, hrdata[0], 0);
    pend_wdata[0] = 32'h0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    idle(0);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);

    // Word write/read, then byte and halfword lane merges.
    issue(0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    issue(0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'h0);
    issue(0, 1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 32'hAA000000);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    issue(0, 1'b1, 2'b10, 1'b1, 32'h10, 3'd1, 32'h00005555);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(0);

    // Out-of-range read, then a misaligned word write that must not land.
    issue(0, 1'b1, 2'b10, 1'b0, MEM, 3'd2, 32'h0);
    idle(0);
    issue(0, 1'b1, 2'b10, 1'b1, 32'h02, 3'd2, 32'h12345678);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h00, 3'd2, 32'h0);
    idle(0);

    // INCR4 with BUSY beats on the zero-wait instance, then read back.
    b = BASES[1];
    issue(1, 1'b1, 2'b10, 1'b1, b,              3'd2, 32'h11111111);
    issue(1, 1'b1, 2'b01, 1'b1, b + 32'h4,      3'd2, 32'hBAD0BAD0);
    issue(1, 1'b1, 2'b11, 1'b1, b + 32'h4,      3'd2, 32'h22222222);
    issue(1, 1'b1, 2'b01, 1'b1, b + 32'h8,      3'd2, 32'hBAD1BAD1);
    issue(1, 1'b1, 2'b11, 1'b1, b + 32'h8,      3'd2, 32'h33333333);
    issue(1, 1'b1, 2'b01, 1'b1, b + 32'hC,      3'd2, 32'hBAD2BAD2);
    issue(1, 1'b1, 2'b11, 1'b1, b + 32'hC,      3'd2, 32'h44444444);
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, 2'b10, 1'b0, b + 32'(i * 4), 3'd2, 32'h0);
    idle(1);

    // Random mix of transfers, idles, BUSY, deselects and error cases.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 300; n++) begin
        k = $urandom_range(0, 19);
        s = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if (k == 0)      a = BASES[d] + MEM + 32'($urandom_range(0, 15));
        else if (k == 1) a = BASES[d] - 32'($urandom_range(1, 8));
        else begin
          a = BASES[d] + 32'($urandom_range(0, 63));
          if (k > 4 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
        end
        case ($urandom_range(0, 9))
          0:       issue(d, 1'($urandom_range(0, 1)), 2'b00, 1'b0, a, s, $urandom);
          1:       issue(d, 1'b1, 2'b01, 1'($urandom_range(0, 1)), a, s, $urandom);
          2:       issue(d, 1'b0, 2'b10, 1'($urandom_range(0, 1)), a, s, $urandom);
          default: issue(d, 1'b1, 2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), a, s, $urandom);
        endcase
      end
      idle(d);
    end

    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("drain", d, expq[d].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
